hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 34 +++
 rtl/hazard_ctrl.sv | 83 ++++++++
 tb/tb_hazard_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle: decode-stage operands, E/M producer info, MD start, and the stall/busy results.
interface hazard_ctrl_if;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [1:0]  D_Tuse_rs;
    logic [1:0]  D_Tuse_rt;
    logic        D_is_md;
    logic [4:0]  E_A3;
    logic [4:0]  M_A3;
    logic [1:0]  E_Tnew;
    logic [1:0]  M_Tnew;
    logic        E_md_start;
    logic        E_md_div;
    logic        Req;
    logic        stall;
    logic        E_clr;
    logic        md_busy;
    logic [15:0] stall_cycles;

    // The pipeline side drives the operands and consumes the stall decision.
    modport master (
        output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
        output E_A3, M_A3, E_Tnew, M_Tnew,
        output E_md_start, E_md_div, Req,
        input  stall, E_clr, md_busy, stall_cycles
    );

    modport slave (
        input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, D_is_md,
        input  E_A3, M_A3, E_Tnew, M_Tnew,
        input  E_md_start, E_md_div, Req,
        output stall, E_clr, md_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: Tuse/Tnew data hazards plus multiply/divide busy tracking.
// Latency: stall/E_clr combinational; md_busy registered from the cycle after the MD start.
// Backpressure: stall freezes F/D and bubbles E; an exception request suppresses the stall.
module hazard_ctrl (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    md_state_t  state;
    md_state_t  state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    logic rs_hazard;
    logic rt_hazard;
    logic md_hazard;
    logic stall_int;

    // Register 0 is hard-wired to zero, so it can never carry a real dependence.
    always_comb begin
        rs_hazard = (hz.D_rs != 5'd0) &&
                    (((hz.D_rs == hz.E_A3) && (hz.E_Tnew > hz.D_Tuse_rs)) ||
                     ((hz.D_rs == hz.M_A3) && (hz.M_Tnew > hz.D_Tuse_rs)));
        rt_hazard = (hz.D_rt != 5'd0) &&
                    (((hz.D_rt == hz.E_A3) && (hz.E_Tnew > hz.D_Tuse_rt)) ||
                     ((hz.D_rt == hz.M_A3) && (hz.M_Tnew > hz.D_Tuse_rt)));
        md_hazard = hz.D_is_md && ((state == BUSY) || hz.E_md_start);
        stall_int = (rs_hazard || rt_hazard || md_hazard) && !hz.Req;
    end

    assign hz.stall   = stall_int;
    assign hz.E_clr   = stall_int;
    assign hz.md_busy = (state == BUSY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A start is dropped if already busy or if the starting instruction is being flushed.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (hz.E_md_start && !hz.Req) begin
                    state_nxt = BUSY;
                    cnt_nxt   = hz.E_md_div ? 4'd10 : 4'd5;
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hz.stall_cycles <= 16'd0;
        end else if (stall_int && (hz.stall_cycles != 16'hFFFF)) begin
            hz.stall_cycles <= hz.stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with an abstract reference model checked every cycle.
module tb_hazard_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    hazard_ctrl_if hz ();

    hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remaining busy cycles and a saturating stall tally.
    int busy_left;
    int sc_model;

    function automatic bit dep(input logic [4:0] src, input logic [1:0] tuse);
        if (src == 5'd0) return 1'b0;
        return ((src == hz.E_A3) && (int'(hz.E_Tnew) > int'(tuse))) ||
               ((src == hz.M_A3) && (int'(hz.M_Tnew) > int'(tuse)));
    endfunction

    function automatic bit model_stall();
        bit md;
        md = hz.D_is_md && ((busy_left > 0) || hz.E_md_start);
        return (dep(hz.D_rs, hz.D_Tuse_rs) || dep(hz.D_rt, hz.D_Tuse_rt) || md) && !hz.Req;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_left = 0;
            sc_model  = 0;
        end else begin
            if (model_stall() && sc_model < 65535) sc_model = sc_model + 1;
            if (busy_left > 0) busy_left = busy_left - 1;
            else if (hz.E_md_start && !hz.Req) busy_left = hz.E_md_div ? 10 : 5;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("model_stall", {31'd0, hz.stall}, {31'd0, model_stall()});
        chk("model_eclr", {31'd0, hz.E_clr}, {31'd0, model_stall()});
        chk("model_busy", {31'd0, hz.md_busy}, {31'd0, busy_left > 0});
        chk("model_cycles", {16'd0, hz.stall_cycles}, sc_model);
    end

    task automatic clear_in();
        hz.D_rs = 0; hz.D_rt = 0; hz.D_Tuse_rs = 0; hz.D_Tuse_rt = 0; hz.D_is_md = 0;
        hz.E_A3 = 0; hz.M_A3 = 0; hz.E_Tnew = 0; hz.M_Tnew = 0;
        hz.E_md_start = 0; hz.E_md_div = 0; hz.Req = 0;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        clear_in();
        #2;
        chk("rst_busy", {31'd0, hz.md_busy}, 32'd0);
        chk("rst_cycles", {16'd0, hz.stall_cycles}, 32'd0);
        chk("rst_stall", {31'd0, hz.stall}, 32'd0);
        step();
        reset = 1'b0;

        // Load-use on rs from E.
        step();
        hz.D_rs = 5; hz.D_Tuse_rs = 0; hz.E_A3 = 5; hz.E_Tnew = 2;
        #2;
        chk("loaduse_stall", {31'd0, hz.stall}, 32'd1);
        chk("loaduse_eclr", {31'd0, hz.E_clr}, 32'd1);
        hz.D_rs = 0;
        #1;
        chk("r0_no_stall", {31'd0, hz.stall}, 32'd0);

        // Register 0 as destination with nonzero Tnew.
        step();
        hz.E_A3 = 0; hz.E_Tnew = 2; hz.D_rt = 0; hz.D_Tuse_rt = 0;
        #2;
        chk("a3_zero", {31'd0, hz.stall}, 32'd0);

        // Forwardable vs. stalling rt dependence on M.
        step();
        clear_in();
        hz.D_rt = 7; hz.D_Tuse_rt = 1; hz.M_A3 = 7; hz.M_Tnew = 1;
        #2;
        chk("fwd_ok", {31'd0, hz.stall}, 32'd0);
        hz.M_Tnew = 2;
        #1;
        chk("fwd_stall", {31'd0, hz.stall}, 32'd1);
        hz.Req = 1;
        #1;
        chk("req_masks", {31'd0, hz.stall}, 32'd0);

        // Multiply: 5 busy cycles, stall covers start plus busy.
        step();
        clear_in();
        hz.D_is_md = 1; hz.E_md_start = 1; hz.E_md_div = 0;
        #2;
        chk("mul_start_stall", {31'd0, hz.stall}, 32'd1);
        chk("mul_start_busy", {31'd0, hz.md_busy}, 32'd0);
        step();
        hz.E_md_start = 0;
        for (int i = 1; i <= 5; i++) begin
            #2;
            chk("mul_busy", {31'd0, hz.md_busy}, 32'd1);
            chk("mul_stall", {31'd0, hz.stall}, 32'd1);
            step();
        end
        #2;
        chk("mul_done_busy", {31'd0, hz.md_busy}, 32'd0);
        chk("mul_done_stall", {31'd0, hz.stall}, 32'd0);

        // Divide with Req in busy cycle 3: runs all 10 cycles.
        step();
        clear_in();
        hz.E_md_start = 1; hz.E_md_div = 1;
        step();
        hz.E_md_start = 0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 3) begin
                hz.Req = 1; hz.D_is_md = 1;
                hz.D_rs = 9; hz.E_A3 = 9; hz.E_Tnew = 2;
                #2;
                chk("div_req_stall", {31'd0, hz.stall}, 32'd0);
            end else begin
                hz.Req = 0; hz.D_is_md = 0; hz.D_rs = 0;
                #2;
            end
            chk("div_busy", {31'd0, hz.md_busy}, 32'd1);
            step();
        end
        clear_in();
        #2;
        chk("div_done", {31'd0, hz.md_busy}, 32'd0);

        // Start while flushing is dropped.
        hz.E_md_start = 1; hz.Req = 1;
        step();
        clear_in();
        #2;
        chk("start_req_idle", {31'd0, hz.md_busy}, 32'd0);

        // Start while busy does not reload.
        hz.E_md_start = 1;
        step();
        for (int i = 1; i <= 5; i++) begin
            hz.E_md_start = (i == 3);
            step();
        end
        hz.E_md_start = 0;
        #2;
        chk("busy_restart_ignored", {31'd0, hz.md_busy}, 32'd0);

        // Asynchronous reset in busy cycle 4 of a divide.
        step();
        hz.E_md_start = 1; hz.E_md_div = 1;
        step();
        hz.E_md_start = 0; hz.E_md_div = 0;
        step(); step(); step();
        #1;
        chk("pre_rst_busy", {31'd0, hz.md_busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, hz.md_busy}, 32'd0);
        chk("async_rst_cycles", {16'd0, hz.stall_cycles}, 32'd0);
        step();
        reset = 1'b0;
        step();
        #2;
        chk("post_rst_idle", {31'd0, hz.md_busy}, 32'd0);

        // Saturation of the stall counter.
        hz.D_rs = 3; hz.D_Tuse_rs = 0; hz.E_A3 = 3; hz.E_Tnew = 1;
        for (int i = 0; i < 70000; i++) step();
        #2;
        chk("sat_reach", {16'd0, hz.stall_cycles}, 32'h0000FFFF);
        for (int i = 0; i < 5; i++) step();
        #2;
        chk("sat_hold", {16'd0, hz.stall_cycles}, 32'h0000FFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
